// File: rtl/hex_keypad_scanner_if.sv
// rtl/hex_keypad_scanner_if.sv - CPU-side read handshake between the keypad scanner and the bus decode
interface hex_keypad_scanner_if;
    logic       rd;
    logic [3:0] key;
    logic       key_ready;
    logic       overrun;

    modport master (output rd, input key, input key_ready, input overrun);
    modport slave  (input rd, output key, output key_ready, output overrun);
endinterface

// File: rtl/hex_keypad_scanner.sv
// rtl/hex_keypad_scanner.sv - 4x4 keypad column scanner, debouncer and one-code-per-press read latch
// Optional auto-repeat while a key is held: KEYPAD_REPEAT_EN
module hex_keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned REPEAT_SCANS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            row_n,
    output logic [3:0]            col_n,
    hex_keypad_scanner_if.slave   bus
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_deb
        $error("DEBOUNCE must be in 1..15");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_rep
        $error("REPEAT_SCANS must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    // Per-scan contact tally: 0 none, 1 single, 2 two or more
    localparam logic [1:0] HITS_NONE   = 2'd0;
    localparam logic [1:0] HITS_SINGLE = 2'd1;
    localparam logic [1:0] HITS_MULTI  = 2'd2;

    logic [3:0]       row_s1_q, row_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       acc_hits_q, acc_hits_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_hits_q, res_hits_d;
    logic [3:0]       res_code_q, res_code_d;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic             key_ready_q, key_ready_d;
    logic             overrun_q, overrun_d;
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    logic             accept;
    logic [3:0]       accept_code;
    logic [1:0]       hits;
    logic [3:0]       code;

    always_comb begin
        div_d       = div_q;
        col_n_d     = col_n_q;
        col_idx_d   = col_idx_q;
        acc_hits_d  = acc_hits_q;
        acc_code_d  = acc_code_q;
        res_valid_d = 1'b0;
        res_hits_d  = res_hits_q;
        res_code_d  = res_code_q;
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_ready_d = key_ready_q;
        overrun_d   = overrun_q;
        accept      = 1'b0;
        accept_code = cand_q;
        hits        = acc_hits_q;
        code        = acc_code_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif

        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d     = '0;
            col_n_d   = {col_n_q[2:0], col_n_q[3]};
            col_idx_d = col_idx_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                if (!row_s2_q[r]) begin
                    if (hits == HITS_NONE) begin
                        code = {2'(r), col_idx_q};
                    end
                    if (hits != HITS_MULTI) begin
                        hits = hits + 2'd1;
                    end
                end
            end
            if (col_idx_q == 2'd3) begin
                res_valid_d = 1'b1;
                res_hits_d  = hits;
                res_code_d  = code;
                acc_hits_d  = HITS_NONE;
                acc_code_d  = 4'h0;
            end else begin
                acc_hits_d  = hits;
                acc_code_d  = code;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // The FSM consumes the scan result one cycle after the column-3 sample
        if (res_valid_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (res_hits_q == HITS_SINGLE) begin
                        cand_d = res_code_q;
                        cnt_d  = 4'd1;
                        if (DEBOUNCE == 1) begin
                            accept      = 1'b1;
                            accept_code = res_code_q;
                            state_d     = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (res_hits_q == HITS_SINGLE && res_code_q == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= 4'(DEBOUNCE)) begin
                            accept  = 1'b1;
                            state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                S_HELD: begin
                    if (res_hits_q == HITS_NONE) begin
                        cnt_d   = 4'd1;
                        state_d = (DEBOUNCE == 1) ? S_IDLE : S_RELEASE;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_q + REP_W'(1) >= REP_W'(REPEAT_SCANS)) begin
                            accept = 1'b1;
                            rep_d  = '0;
                        end else begin
                            rep_d  = rep_q + REP_W'(1);
                        end
`endif
                    end
                end
                S_RELEASE: begin
                    if (res_hits_q == HITS_NONE) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= 4'(DEBOUNCE)) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // An accept in the same cycle as rd wins; rd only acknowledges the old code
        if (accept) begin
            key_d       = accept_code;
            key_ready_d = 1'b1;
            overrun_d   = key_ready_q && !bus.rd;
        end else if (bus.rd && key_ready_q) begin
            key_ready_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            div_q       <= '0;
            col_n_q     <= 4'b1110;
            col_idx_q   <= 2'd0;
            acc_hits_q  <= HITS_NONE;
            acc_code_q  <= 4'h0;
            res_valid_q <= 1'b0;
            res_hits_q  <= HITS_NONE;
            res_code_q  <= 4'h0;
            state_q     <= S_IDLE;
            cand_q      <= 4'h0;
            cnt_q       <= 4'd0;
            key_q       <= 4'h0;
            key_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            row_s1_q    <= row_n;
            row_s2_q    <= row_s1_q;
            div_q       <= div_d;
            col_n_q     <= col_n_d;
            col_idx_q   <= col_idx_d;
            acc_hits_q  <= acc_hits_d;
            acc_code_q  <= acc_code_d;
            res_valid_q <= res_valid_d;
            res_hits_q  <= res_hits_d;
            res_code_q  <= res_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_ready_q <= key_ready_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col_n         = col_n_q;
    assign bus.key       = key_q;
    assign bus.key_ready = key_ready_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb/tb_hex_keypad_scanner.sv - self-checking bench for hex_keypad_scanner (SCAN_DIV=4, DEBOUNCE=3)
module tb_hex_keypad_scanner;
    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] pressed = 16'h0;
    logic        rd_man = 1'b0;
    logic        rd_auto = 1'b0;
    logic        rd_auto_en = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    hex_keypad_scanner_if bus ();
    assign bus.rd = rd_man | rd_auto;

    hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_SCANS(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .row_n (row_n),
        .col_n (col_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Keypad matrix: contact r*4+c pulls row r low while column c is driven
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    typedef struct {
        logic [3:0] key;
        logic       ovr;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [15:0] mask;
        logic        acc;
        logic [3:0]  key;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = rst_n ? cyc + 1 : 0;
    end

    initial forever begin
        @(negedge clk);
        rd_auto = rd_auto_en && bus.key_ready;
    end

    // Accept monitor: a rising key_ready or a new code while ready marks an accept
    logic [3:0] prev_key = 4'h0;
    logic       prev_ready = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.key_ready && (!prev_ready || bus.key != prev_key)) begin
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("acc_key", 32'(bus.key), 32'(e.key));
                check("acc_overrun", 32'(bus.overrun), 32'(e.ovr));
                check("acc_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_key   = bus.key;
        prev_ready = bus.key_ready;
    end

    task automatic push(input logic [3:0] k, input logic o, input int c);
        exp_t e;
        e.key = k; e.ovr = o; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_man = 1'b0;
        rd_auto_en = 1'b0;
        pressed = 16'h0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_scans(input logic [15:0] mask, input int n);
        pressed = mask;
        repeat (n * SCAN) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        rd_man = 1'b1;
        @(posedge clk);
        #1;
        rd_man = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clk);
        #1;
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    function automatic logic [15:0] bit_of(input int k);
        logic [15:0] m;
        m = 16'h0;
        m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v.mask = bit_of(i); v.acc = 1'b1; v.key = 4'(i);
            vecs.push_back(v);
        end
        vecs.push_back('{16'h0000, 1'b0, 4'h0});
        vecs.push_back('{16'h0003, 1'b0, 4'h0});
        vecs.push_back('{16'h0011, 1'b0, 4'h0});
        vecs.push_back('{16'h8421, 1'b0, 4'h0});
        vecs.push_back('{16'hFFFF, 1'b0, 4'h0});

        // Table: each contact pattern held for 4 scans from reset
        foreach (vecs[i]) begin
            do_reset();
            check("rst_col", 32'(col_n), 32'hE);
            if (vecs[i].acc) push(vecs[i].key, 1'b0, 3*SCAN + 1);
            run_scans(vecs[i].mask, 4);
            check("vec_ready", 32'(bus.key_ready), 32'(vecs[i].acc));
            check("vec_overrun", 32'(bus.overrun), 32'd0);
            drain("vec_drained");
        end

        // Asynchronous reset mid-scan with a key latched
        do_reset();
        push(4'h9, 1'b0, 3*SCAN + 1);
        run_scans(bit_of(9), 4);
        repeat (5) @(posedge clk);
        #1;
        check("mid_col", 32'(col_n), 32'hD);
        check("mid_ready", 32'(bus.key_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_col", 32'(col_n), 32'hE);
        check("arst_key", 32'(bus.key), 32'h0);
        check("arst_ready", 32'(bus.key_ready), 32'd0);
        check("arst_overrun", 32'(bus.overrun), 32'd0);
        pressed = 16'h0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_col1", 32'(col_n), 32'hD);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_col2", 32'(col_n), 32'hB);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_col3", 32'(col_n), 32'h7);

        // Clean press of 9 held 5 scans, then read
        do_reset();
        push(4'h9, 1'b0, 3*SCAN + 1);
        run_scans(bit_of(9), 5);
        check("clean_key", 32'(bus.key), 32'h9);
        check("clean_ready", 32'(bus.key_ready), 32'd1);
        pulse_rd();
        check("clean_rd_ready", 32'(bus.key_ready), 32'd0);
        check("clean_rd_key", 32'(bus.key), 32'h9);
        drain("clean_drained");

        // Bounce: present/absent on alternate scans, then a stable hold
        do_reset();
        for (int i = 0; i < 8; i++) run_scans((i % 2 == 0) ? bit_of(9) : 16'h0, 1);
        check("bounce_ready", 32'(bus.key_ready), 32'd0);
        push(4'h9, 1'b0, 11*SCAN + 1);
        run_scans(bit_of(9), 3);
        drain("bounce_drained");

        // Ghost: 5 and 6 together, then 6 released
        do_reset();
        run_scans(bit_of(5) | bit_of(6), 4);
        check("ghost_ready", 32'(bus.key_ready), 32'd0);
        push(4'h5, 1'b0, 7*SCAN + 1);
        run_scans(bit_of(5), 3);
        drain("ghost_drained");

        // Overrun then rd colliding with an accept
        do_reset();
        push(4'h3, 1'b0, 3*SCAN + 1);
        run_scans(bit_of(3), 3);
        run_scans(16'h0, 3);
        push(4'hA, 1'b1, 9*SCAN + 1);
        run_scans(bit_of(10), 3);
        run_scans(16'h0, 3);
        check("ovr_key", 32'(bus.key), 32'hA);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        push(4'hC, 1'b0, 15*SCAN + 1);
        run_scans(bit_of(12), 3);
        pulse_rd();
        check("coll_key", 32'(bus.key), 32'hC);
        check("coll_ready", 32'(bus.key_ready), 32'd1);
        check("coll_overrun", 32'(bus.overrun), 32'd0);
        drain("coll_drained");

        // Hold F for 9 scans with a read after each accept
        do_reset();
        rd_auto_en = 1'b1;
        push(4'hF, 1'b0, 3*SCAN + 1);
`ifdef KEYPAD_REPEAT_EN
        push(4'hF, 1'b0, 5*SCAN + 1);
        push(4'hF, 1'b0, 7*SCAN + 1);
        push(4'hF, 1'b0, 9*SCAN + 1);
`endif
        run_scans(bit_of(15), 9);
        drain("repeat_drained");
        rd_auto_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hex_keypad_scanner.md
# hex_keypad_scanner

Scans a 4x4 matrix hex keypad, debounces it and presents one 4-bit key code per press to the CPU bus through a ready/read handshake. It is the input-side counterpart of the 7-segment hex display path: the display turns a byte into segment patterns, and this block turns physical key contacts back into nibbles. It sits between the keypad pins and the memory-mapped I/O decode of the 6502 system.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before its rows are sampled; must be at least 4.
- `DEBOUNCE`, default 4: consecutive identical full-scan results required to accept a press or a release; range 1..15.
- `REPEAT_SCANS`, default 64: full scans between auto-repeat events; only used with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock; all logic is in this single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `row_n`  in  4  keypad rows; active-low, externally pulled up, asynchronous to `clk`.
- `col_n`  out  4  column drive; active-low, exactly one bit low at all times.
- `rd`  in  1  one-cycle strobe from the bus: the CPU has read `key`.
- `key`  out  4  last accepted key code, `{row[1:0], col[1:0]}`.
- `key_ready`  out  1  an unread key is held in `key`.
- `overrun`  out  1  a key was accepted while `key_ready` was already 1.

## Operation
- `row_n` passes through a 2-flop synchronizer before any use.
- Scan counter:
  - The dwell counter runs 0..`SCAN_DIV`-1 on every cycle.
  - At the terminal count, the synchronized rows are sampled for the current column, then `col_n` rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - One full scan takes 4*`SCAN_DIV` cycles.
- Scan result, evaluated after the column-3 sample:
  - NONE: no contact.
  - SINGLE(code): exactly one contact.
  - MULTI: two or more contacts; treated as "not a new key".
- FSM states:
  - IDLE: SINGLE(k) -> DEBOUNCE with cand=k, cnt=1. Any other result: stay.
  - DEBOUNCE: SINGLE(cand) -> cnt+1. When cnt reaches `DEBOUNCE`: accept cand, go to HELD. Any other result -> IDLE. `DEBOUNCE`=1 accepts on the first SINGLE directly from IDLE.
  - HELD: NONE -> RELEASE with cnt=1. SINGLE or MULTI: stay. A key change while held is not reported.
  - RELEASE: NONE -> cnt+1; IDLE when cnt reaches `DEBOUNCE`. SINGLE or MULTI -> HELD.
- Accept:
  - `key` is loaded with the code and `key_ready` is set.
  - `overrun` is set if `key_ready` was already 1; the old code is overwritten.
- `rd` clears `key_ready` and `overrun`. `rd` while `key_ready`=0 has no effect.
- Simultaneous `rd` and accept in the same cycle: the accept wins. `key` takes the new code, `key_ready` stays 1, `overrun` is 0.

## Timing
- All outputs are registered.
- Reset values:
  - `col_n`=4'b1110
  - `key`=4'h0
  - `key_ready`=0
  - `overrun`=0
  - FSM in IDLE, all counters 0
- `rst_n` asserted mid-scan or mid-debounce aborts everything immediately. Scanning restarts at column 0 after release.
- Row sampling happens `SCAN_DIV`-1 cycles after the column switches, which gives the pins time to settle. The 2-flop synchronizer adds 2 cycles of delay.
- Accept latency: `key`/`key_ready` update on the clock edge after the column-3 sample that completes the `DEBOUNCE`-th matching scan.
- `rd` takes effect on the next clock edge.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a repeat counter counts full scans.
  - Every `REPEAT_SCANS` scans, the held code is accepted again, with the same `key_ready`/`overrun` rules.
  - The counter resets on entry to HELD and on each repeat.
- `KEYPAD_REPEAT_EN` undefined: no repeat counter is built, and exactly one accept occurs per press.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3 unless stated; one scan is then 16 cycles.
- Reset: assert `rst_n`=0 mid-scan -> `col_n`=1110, `key_ready`=0, `overrun`=0, `key`=0 immediately. After release, the column advances every 4 cycles.
- Clean press: hold row 2 low while column 1 is driven (code 4'h9) for 5 scans -> `key`=9 and `key_ready`=1 one edge after the 3rd scan's column-3 sample. No further accept while held. `rd` clears `key_ready`.
- Bounce: toggle contact 9 as present/absent on alternate scans for 8 scans -> `key_ready` never asserts. A subsequent stable 3-scan hold is accepted.
- Ghost: hold codes 5 and 6 together -> no accept. Release 6 -> code 5 accepted after 3 scans.
- Overrun and collision:
  - Press 3, release, press A without `rd` -> `key`=A, `overrun`=1.
  - Pulse `rd` on the exact accept edge of a third key C -> `key`=C, `key_ready`=1, `overrun`=0.
- Repeat, with `KEYPAD_REPEAT_EN` and `REPEAT_SCANS`=2: hold key F for 9 scans with `rd` after each accept -> accepts after scans 3, 5, 7 and 9. Without the macro, a single accept only.
